// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: state encodings and counter width shared by the PC sequencer
package pc_seq_pkg;
  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_RUN   = 2'd1,
    S_WAIT  = 2'd2,
    S_HALT  = 2'd3
  } state_t;
  localparam int CNT_W = 16;
endpackage

// File: rtl/pc_next_sel.sv
// pc_next_sel: priority mux and adder choosing the next PC
// ports: pc/valid plus trap, stall, halt, jmp/jmp_tgt, br_taken/br_off controls in;
//        pc_nxt, retire, trap_take, halt_take out
module pc_next_sel #(
  parameter int N = 9,
  parameter logic [N-1:0] TRAP_VEC = {N{1'b1}}
) (
  input  logic [N-1:0] pc,
  input  logic         valid,
  input  logic         trap,
  input  logic         stall,
  input  logic         halt,
  input  logic         jmp,
  input  logic [N-1:0] jmp_tgt,
  input  logic         br_taken,
  input  logic [N-1:0] br_off,
  output logic [N-1:0] pc_nxt,
  output logic         retire,
  output logic         trap_take,
  output logic         halt_take
);
  assign trap_take = valid & trap;
  assign retire    = valid & ~stall & ~trap;
  assign halt_take = retire & halt;
  // br_off is already N bits, so modulo-2^N addition gives the sign extension for free
  assign pc_nxt = !valid          ? pc :
                  trap            ? TRAP_VEC :
                  (stall || halt) ? pc :
                  jmp             ? jmp_tgt :
                  br_taken        ? pc + N'(1) + br_off :
                                    pc + N'(1);
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter owner with run/step/stall/halt/trap control
// ports: btn clock, rst async reset, run_mode/step/resume execution control,
//        stall/br_taken/br_off/jmp/jmp_tgt/trap/halt from decode;
//        pc, pc_valid, epc, state, instr_cnt out
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int N = 9,
  parameter logic [N-1:0] RST_VEC  = {N{1'b0}},
  parameter logic [N-1:0] TRAP_VEC = {N{1'b1}}
) (
  input  logic             btn,
  input  logic             rst,
  input  logic             run_mode,
  input  logic             step,
  input  logic             stall,
  input  logic             br_taken,
  input  logic [N-1:0]     br_off,
  input  logic             jmp,
  input  logic [N-1:0]     jmp_tgt,
  input  logic             trap,
  input  logic             halt,
  input  logic             resume,
  output logic [N-1:0]     pc,
  output logic             pc_valid,
  output logic [N-1:0]     epc,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] instr_cnt
);
  state_t st;
  logic step_q, step_edge, retire, trap_take, halt_take;
  logic [N-1:0] pc_nxt;
  assign step_edge = step & ~step_q;
  assign pc_valid  = (st == S_RUN) | ((st == S_WAIT) & step_edge);
  assign state     = st;
  pc_next_sel #(.N(N), .TRAP_VEC(TRAP_VEC)) u_sel (
    .pc(pc), .valid(pc_valid), .trap(trap), .stall(stall), .halt(halt),
    .jmp(jmp), .jmp_tgt(jmp_tgt), .br_taken(br_taken), .br_off(br_off),
    .pc_nxt(pc_nxt), .retire(retire), .trap_take(trap_take), .halt_take(halt_take)
  );
  always_ff @(posedge btn or posedge rst) begin
    if (rst) begin
      st        <= S_RESET;
      pc        <= RST_VEC;
      epc       <= '0;
      instr_cnt <= '0;
      step_q    <= 1'b0;
    end else begin
      step_q <= step;
      case (st)
        S_RESET: st <= run_mode ? S_RUN : S_WAIT;
        S_HALT: if (resume) begin
          pc <= pc + N'(1);
          st <= run_mode ? S_RUN : S_WAIT;
        end
        default: begin
          // in WAIT without a step edge pc_valid is 0, so the selector holds everything
          pc <= pc_nxt;
          if (trap_take) epc <= pc;
          if (retire && instr_cnt != '1) instr_cnt <= instr_cnt + CNT_W'(1);
          st <= halt_take ? S_HALT : run_mode ? S_RUN : S_WAIT;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scoreboard bench for pc_sequencer
module tb_pc_sequencer;
  typedef struct {
    logic [8:0]  pc;
    logic [15:0] cnt;
    logic [1:0]  st;
  } exp_t;
  logic btn = 0, rst = 1, run_mode = 1, step = 0, stall = 0, br_taken = 0;
  logic jmp = 0, trap = 0, halt = 0, resume = 0;
  logic [8:0] br_off = 0, jmp_tgt = 0, pc, epc;
  logic pc_valid;
  logic [1:0] state;
  logic [15:0] instr_cnt;
  int errors = 0, checks = 0;
  exp_t q[$];
  exp_t e;
  pc_sequencer dut (
    .btn(btn), .rst(rst), .run_mode(run_mode), .step(step), .stall(stall),
    .br_taken(br_taken), .br_off(br_off), .jmp(jmp), .jmp_tgt(jmp_tgt),
    .trap(trap), .halt(halt), .resume(resume), .pc(pc), .pc_valid(pc_valid),
    .epc(epc), .state(state), .instr_cnt(instr_cnt)
  );
  always #5 btn = ~btn;
  task tick;
    @(posedge btn);
    #1;
  endtask
  task automatic test_reset;
    #12;
    checks++;
    if ({pc, epc, instr_cnt, state, pc_valid} !== {9'h000, 9'h000, 16'd0, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset: pc=%h epc=%h cnt=%0d st=%0d v=%b want 000 000 0 0 0", pc, epc, instr_cnt, state, pc_valid);
    end
    rst = 0;
    #1;
  endtask
  task automatic test_run;
    for (int i = 0; i < 6; i++) begin
      q.push_back('{9'(i), 16'(i), 2'd1});
      tick();
      e = q.pop_front();
      checks++;
      if ({pc, instr_cnt, state, pc_valid} !== {e.pc, e.cnt, e.st, 1'b1}) begin
        errors++;
        $display("FAIL run[%0d]: pc=%h cnt=%0d st=%0d v=%b want pc=%h cnt=%0d st=%0d v=1", i, pc, instr_cnt, state, pc_valid, e.pc, e.cnt, e.st);
      end
    end
  endtask
  task automatic test_branch_jump;
    for (int i = 0; i < 3; i++) begin
      br_taken = (i == 0); br_off = 9'h1FD;
      jmp = (i == 1); jmp_tgt = 9'h1FF;
      q.push_back(i == 0 ? '{9'h003, 16'd6, 2'd1} : i == 1 ? '{9'h1FF, 16'd7, 2'd1} : '{9'h000, 16'd8, 2'd1});
      tick();
      e = q.pop_front();
      checks++;
      if ({pc, instr_cnt, state} !== {e.pc, e.cnt, e.st}) begin
        errors++;
        $display("FAIL brjmp[%0d]: pc=%h cnt=%0d st=%0d want pc=%h cnt=%0d st=%0d", i, pc, instr_cnt, state, e.pc, e.cnt, e.st);
      end
    end
    br_taken = 0; jmp = 0;
  endtask
  task automatic test_trap_stall;
    for (int i = 0; i < 6; i++) begin
      jmp = (i == 0); jmp_tgt = 9'h010;
      stall = (i >= 1); trap = (i == 1);
      q.push_back(i == 0 ? '{9'h010, 16'd9, 2'd1} : '{9'h1FF, 16'd9, 2'd1});
      tick();
      e = q.pop_front();
      checks++;
      if ({pc, instr_cnt, state} !== {e.pc, e.cnt, e.st} || (i >= 1 && epc !== 9'h010)) begin
        errors++;
        $display("FAIL trapstall[%0d]: pc=%h cnt=%0d st=%0d epc=%h want pc=%h cnt=%0d st=%0d epc=010", i, pc, instr_cnt, state, epc, e.pc, e.cnt, e.st);
      end
    end
    stall = 0; trap = 0; jmp = 0;
  endtask
  task automatic test_single_step;
    run_mode = 0;
    for (int i = 0; i < 9; i++) begin
      step = (i >= 2 && i <= 6) || i == 8;
      #1;
      checks++;
      if (pc_valid !== (i == 0 || i == 2 || i == 8)) begin
        errors++;
        $display("FAIL step_valid[%0d]: pc_valid=%b want %b", i, pc_valid, (i == 0 || i == 2 || i == 8));
      end
      q.push_back(i < 2 ? '{9'h000, 16'd10, 2'd2} : i < 8 ? '{9'h001, 16'd11, 2'd2} : '{9'h002, 16'd12, 2'd2});
      tick();
      e = q.pop_front();
      checks++;
      if ({pc, instr_cnt, state} !== {e.pc, e.cnt, e.st}) begin
        errors++;
        $display("FAIL step[%0d]: pc=%h cnt=%0d st=%0d want pc=%h cnt=%0d st=%0d", i, pc, instr_cnt, state, e.pc, e.cnt, e.st);
      end
    end
    step = 0;
  endtask
  task automatic test_halt;
    run_mode = 1;
    for (int i = 0; i < 6; i++) begin
      jmp = (i == 1); jmp_tgt = 9'h007;
      halt = (i == 2 || i == 3 || i == 5);
      trap = (i == 3 || i == 5);
      resume = (i == 4);
      q.push_back(i == 0 ? '{9'h002, 16'd12, 2'd1} : i == 1 ? '{9'h007, 16'd13, 2'd1} :
                  i < 4  ? '{9'h007, 16'd14, 2'd3} : i == 4 ? '{9'h008, 16'd14, 2'd1} :
                           '{9'h1FF, 16'd14, 2'd1});
      tick();
      e = q.pop_front();
      checks++;
      if ({pc, instr_cnt, state} !== {e.pc, e.cnt, e.st} || (i == 5 && epc !== 9'h008) || (i == 3 && epc !== 9'h010)) begin
        errors++;
        $display("FAIL halt[%0d]: pc=%h cnt=%0d st=%0d epc=%h want pc=%h cnt=%0d st=%0d", i, pc, instr_cnt, state, epc, e.pc, e.cnt, e.st);
      end
    end
    jmp = 0; halt = 0; trap = 0; resume = 0;
  endtask
  task automatic test_reset_mid;
    jmp = 1; jmp_tgt = 9'h042;
    q.push_back('{9'h042, 16'd15, 2'd1});
    tick();
    jmp = 0;
    e = q.pop_front();
    checks++;
    if ({pc, instr_cnt, state} !== {e.pc, e.cnt, e.st}) begin
      errors++;
      $display("FAIL pre_rst: pc=%h cnt=%0d st=%0d want pc=%h cnt=%0d st=%0d", pc, instr_cnt, state, e.pc, e.cnt, e.st);
    end
    #2 rst = 1;
    #1;
    checks++;
    if ({pc, epc, instr_cnt, state, pc_valid} !== {9'h000, 9'h000, 16'd0, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL mid_rst: pc=%h epc=%h cnt=%0d st=%0d v=%b want 000 000 0 0 0", pc, epc, instr_cnt, state, pc_valid);
    end
    #1 rst = 0;
    q.push_back('{9'h000, 16'd0, 2'd1});
    tick();
    e = q.pop_front();
    checks++;
    if ({pc, instr_cnt, state, pc_valid} !== {e.pc, e.cnt, e.st, 1'b1}) begin
      errors++;
      $display("FAIL post_rst: pc=%h cnt=%0d st=%0d v=%b want pc=%h cnt=%0d st=%0d v=1", pc, instr_cnt, state, pc_valid, e.pc, e.cnt, e.st);
    end
  endtask
  initial begin
    test_reset();
    test_run();
    test_branch_jump();
    test_trap_stall();
    test_single_step();
    test_halt();
    test_reset_mid();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard: %0d left want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Next-PC controller for the single-clock CPU. It owns the program counter register and picks the next fetch address from sequential, branch, jump and trap sources. It also gates execution with run, single-step, stall and halt control, so the board can step one instruction per button press or run freely. It sits between the control unit (branch/jump/trap/halt decode) and instruction memory.

## Interface
- `N`, 9: PC width; instruction memory is word-addressed, 2^N words.
- `RST_VEC`, `{N{1'b0}}`: PC value loaded by reset.
- `TRAP_VEC`, `{N{1'b1}}`: PC loaded on trap.
- `btn`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `run_mode`  in  1  1 = free run; 0 = single-step.
- `step`  in  1  step request level; one step per rising edge of this signal.
- `stall`  in  1  hold the current PC; no retire.
- `br_taken`  in  1  conditional branch taken.
- `br_off`  in  N  signed branch offset, in words.
- `jmp`  in  1  absolute jump.
- `jmp_tgt`  in  N  jump target.
- `trap`  in  1  trap request.
- `halt`  in  1  the current instruction is HALT.
- `resume`  in  1  leave HALT.
- `pc`  out  N  current fetch address.
- `pc_valid`  out  1  the instruction at `pc` executes this cycle.
- `epc`  out  N  PC of the trapped instruction.
- `state`  out  2  FSM state, for debug LEDs.
- `instr_cnt`  out  16  count of retired instructions.

## Operation
- States: RESET(0), RUN(1), WAIT(2), HALT(3).
- Async reset drives these values: `state`=RESET, `pc`=RST_VEC, `epc`=0, `instr_cnt`=0, `step_q`=0. `pc_valid`=0.
- `step_edge` = `step & ~step_q`. `step_q` registers `step` every cycle, in every state.
- `pc_valid` = (state==RUN) | (state==WAIT & step_edge).
- RESET: `pc_valid`=0. The next state is RUN if `run_mode`, else WAIT. `pc` holds.
- When `pc_valid`=1, the next PC uses this priority:
  1. `trap`: `pc`←TRAP_VEC, `epc`←`pc`. This is taken even when `stall`=1.
  2. `stall`: `pc` holds. No retire. `halt` is ignored.
  3. `halt`: `pc` holds. State goes to HALT. Counts as a retire.
  4. `jmp`: `pc`←`jmp_tgt`.
  5. `br_taken`: `pc`←`pc`+1+`br_off`.
  6. Otherwise: `pc`←`pc`+1.
- Retire means `pc_valid & ~stall & ~trap`. Each retire increments `instr_cnt`, which saturates at 16'hFFFF.
- All PC arithmetic is modulo 2^N. `br_off` is sign-extended. `pc`=2^N−1 with a sequential step wraps to 0.
- RUN goes to WAIT when `run_mode`=0, sampled each cycle. The advance in that cycle still happens.
- WAIT goes to RUN when `run_mode`=1. No advance happens in the switching cycle unless `step_edge` is also present. If `step_edge` is present, it is honoured once.
- HALT: `pc_valid`=0 and `pc` holds. `resume`=1 sets `pc`←`pc`+1, and the next state is RUN if `run_mode`, else WAIT. `trap` and `step` are ignored in HALT.
- Inputs other than `run_mode`/`resume`/`step` are ignored whenever `pc_valid`=0.

## Timing
- The next PC is visible on `pc` one `btn` edge after the cycle it was selected in. Branch and jump have no delay slot.
- `epc` and `instr_cnt` update on the same edge as `pc`.
- `rst` asserted mid-run aborts immediately and asynchronously. The in-flight instruction is neither retired nor recorded in `epc`.
- The first edge after `rst` falls always leaves RESET. The first instruction at RST_VEC executes on the following cycle (RUN), or on the first `step_edge` (WAIT).
- Holding `step` high yields exactly one step. A new step needs `step` low for at least one edge.
- When `trap` and `halt` occur together, the trap wins and the state stays RUN/WAIT.

## Structure
- Package `pc_seq_pkg`: state encodings `S_RESET`, `S_RUN`, `S_WAIT`, `S_HALT`, and the `instr_cnt` width (16).
- One sub-module, `pc_next_sel`: the combinational priority mux and adder, producing the next PC and a retire flag.
- The top level holds the FSM, step edge detect, PC, EPC and counter registers.

## Test plan
- Reset then free run, `run_mode`=1, RST_VEC=0: `pc` reads 0 in RESET, then 0,1,2,3 on successive cycles. `instr_cnt`=3 after three RUN cycles.
- Branch/jump/wrap: at `pc`=5 with `br_off`=−3 → `pc`=3. At `pc`=3 with `jmp`, `jmp_tgt`=0x1FF → 0x1FF, then a sequential step → 0x000.
- Trap under stall: at `pc`=0x10 with `stall`=1 and `trap`=1 → `pc`=0x1FF, `epc`=0x10, `instr_cnt` unchanged. `stall` alone holds `pc` for 4 cycles with `instr_cnt` frozen.
- Single step: `run_mode`=0, `step` held high for 5 cycles → `pc` advances by exactly 1 and `pc_valid` pulses for one cycle. A low-then-high on `step` gives one more advance.
- Halt/resume: `halt` at `pc`=7 → state=3, `pc` stays 7 and `instr_cnt` increments once. `resume` with `run_mode`=1 → `pc`=8, state=1.
- Reset mid-run at `pc`=0x42 → `pc`=RST_VEC immediately without waiting for a `btn` edge, and `epc`=0, `instr_cnt`=0, `state`=0.
